// File: rtl/hp_fp_pkg.sv
// Shared constants and types for the half-precision divider.
// Contents: exponent bias and saturation limit, mantissa and quotient widths,
// exception codes, and the FSM state type with its encodings.
package hp_fp_pkg;

    // Signed 7-bit so that exponent arithmetic and compares stay in one type.
    localparam logic signed [6:0] EXP_BIAS = 7'sd15;
    localparam logic signed [6:0] EXP_MAX  = 7'sd31;

    localparam int MANT_W = 11;   // hidden bit + 10 fraction bits
    localparam int ITER   = 12;   // quotient bits produced by the divider

    localparam logic [1:0] EXC_NORMAL    = 2'b00;
    localparam logic [1:0] EXC_OVERFLOW  = 2'b01;
    localparam logic [1:0] EXC_UNDERFLOW = 2'b10;
    localparam logic [1:0] EXC_SPECIAL   = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_DIVIDE = 2'd1;
    localparam state_t S_NORM   = 2'd2;
    localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/hp_divider_if.sv
// Request/result bundle of the half-precision divider.
// Handshake: start is a single-cycle request that is accepted only while busy
// is low; an accepted request produces exactly one done pulse, and
// hp_quotient/Exceptions are valid from that pulse until the next one.
// Signals: start, hp_inA, hp_inB (requester -> divider); hp_quotient,
// Exceptions, busy, done, dbg_state (divider -> requester).
interface hp_divider_if;
    import hp_fp_pkg::*;

    logic        start;
    logic [15:0] hp_inA;
    logic [15:0] hp_inB;
    logic [15:0] hp_quotient;
    logic [1:0]  Exceptions;
    logic        busy;
    logic        done;
    state_t      dbg_state;

    modport master (
        output start, hp_inA, hp_inB,
        input  hp_quotient, Exceptions, busy, done, dbg_state
    );

    modport slave (
        input  start, hp_inA, hp_inB,
        output hp_quotient, Exceptions, busy, done, dbg_state
    );

endinterface

// File: rtl/hp_div_mant.sv
// Iterative restoring divider for 11-bit mantissas, one quotient bit per step.
// Ports: clk, rst (sync, active high); load captures ma/mb and clears the
// quotient; step produces the next quotient bit MSB-first; q is the 12-bit
// quotient after ITER steps.
module hp_div_mant
    import hp_fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] ma,
    input  logic [MANT_W-1:0] mb,
    output logic [ITER-1:0]   q
);

    // One extra bit: after a shift the remainder can reach 2*mb - 2.
    logic [MANT_W:0]   rem;
    logic [MANT_W-1:0] div;
    logic              ge;
    logic [MANT_W:0]   diff;

    always_comb begin
        ge   = (rem >= {1'b0, div});
        diff = ge ? (rem - {1'b0, div}) : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            div <= '0;
            q   <= '0;
        end else if (load) begin
            rem <= {1'b0, ma};
            div <= mb;
            q   <= '0;
        end else if (step) begin
            q   <= {q[ITER-2:0], ge};
            rem <= diff << 1;
        end
    end

endmodule

// File: rtl/hp_divider.sv
// IEEE half-precision divider with fixed 14-cycle latency, truncating result.
// Ports: clk, rst (sync, active high) and the slave side of hp_divider_if.
// Flow: IDLE captures operands on start, DIVIDE runs 12 mantissa steps, NORM
// aligns the quotient, DONE applies special cases and publishes the result.
module hp_divider
    import hp_fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hp_divider_if.slave  bus
);

    state_t             state;
    logic [3:0]         iter_cnt;
    logic               sign_r;
    logic signed [6:0]  exp_r;
    logic               a_zero_r;
    logic               special_r;
    logic [9:0]         frac_r;
    logic [15:0]        quot_r;
    logic [1:0]         exc_r;
    logic               busy_r;
    logic               done_r;

    logic               load;
    logic               step;
    logic [MANT_W-1:0]  ma;
    logic [MANT_W-1:0]  mb;
    logic [ITER-1:0]    q;
    logic [15:0]        res_q;
    logic [1:0]         res_e;

    assign load = (state == S_IDLE) && bus.start;
    assign step = (state == S_DIVIDE);

    // A zero operand gets a zero mantissa; any other value, exponent 0
    // included, is given the hidden 1.
    assign ma = (bus.hp_inA[14:0] == 15'd0) ? '0 : {1'b1, bus.hp_inA[9:0]};
    assign mb = (bus.hp_inB[14:0] == 15'd0) ? '0 : {1'b1, bus.hp_inB[9:0]};

    hp_div_mant u_mant (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .ma   (ma),
        .mb   (mb),
        .q    (q)
    );

    always_comb begin
        res_q = {sign_r, exp_r[4:0], frac_r};
        res_e = EXC_NORMAL;
        if (special_r) begin
            res_q = {sign_r, 5'd31, 10'd0};
            res_e = EXC_SPECIAL;
        end else if (a_zero_r) begin
            res_q = {sign_r, 15'd0};
            res_e = EXC_NORMAL;
        end else if (exp_r >= EXP_MAX) begin
            res_q = {sign_r, 5'd31, 10'd0};
            res_e = EXC_OVERFLOW;
        end else if (exp_r <= 7'sd0) begin
            res_q = {sign_r, 15'd0};
            res_e = EXC_UNDERFLOW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            iter_cnt  <= '0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            a_zero_r  <= 1'b0;
            special_r <= 1'b0;
            frac_r    <= '0;
            quot_r    <= '0;
            exc_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sign_r    <= bus.hp_inA[15] ^ bus.hp_inB[15];
                        // Modulo-128 arithmetic gives the signed 7-bit result.
                        exp_r     <= $signed({2'b00, bus.hp_inA[14:10]})
                                   - $signed({2'b00, bus.hp_inB[14:10]})
                                   + EXP_BIAS;
                        a_zero_r  <= (bus.hp_inA[14:0] == 15'd0);
                        special_r <= (bus.hp_inA[14:10] == 5'd31)
                                  || (bus.hp_inB[14:10] == 5'd31)
                                  || (bus.hp_inB[14:0] == 15'd0);
                        iter_cnt  <= '0;
                        busy_r    <= 1'b1;
                        state     <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    iter_cnt <= iter_cnt + 4'd1;
                    if (iter_cnt == 4'(ITER - 1)) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    // Quotient of two [1,2) mantissas lies in (0.5,2).
                    if (q[ITER-1]) begin
                        frac_r <= q[10:1];
                    end else begin
                        frac_r <= q[9:0];
                        exp_r  <= exp_r - 7'sd1;
                    end
                    state <= S_DONE;
                end
                default: begin
                    quot_r <= res_q;
                    exc_r  <= res_e;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hp_quotient = quot_r;
    assign bus.Exceptions  = exc_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.dbg_state   = state;

endmodule

// File: doc/hp_divider.md
HP_DIVIDER -- requirements
Module: hp_divider

Interface
REQ-001 The interface SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port start  input  1  request; sampled only in IDLE.
REQ-005 Port hp_inA  input  16  dividend, IEEE half-precision {sign, exp[4:0], frac[9:0]}.
REQ-006 Port hp_inB  input  16  divisor, same format.
REQ-007 Port hp_quotient  output  16  result, half-precision.
REQ-008 Port Exceptions  output  2  00 normal, 01 overflow, 10 underflow, 11 inf/NaN operand or divide-by-zero.
REQ-009 Port busy  output  1  high while an operation is in flight.
REQ-010 Port done  output  1  one-cycle pulse; result valid.

Function
REQ-011 The FSM SHALL have states IDLE, DIVIDE, NORM and DONE, with transitions: IDLE->DIVIDE on start; DIVIDE->NORM after 12 iterations; NORM->DONE; DONE->IDLE unconditionally.
REQ-012 On start in IDLE, operands SHALL be captured into internal registers; later input changes have no effect.
REQ-013 Latency SHALL be fixed: start sampled at edge N; busy high from edge N+1 through edge N+14; done high for exactly one cycle starting at edge N+14.
REQ-014 Special-case operands SHALL take the same fixed latency.
REQ-015 start while busy SHALL be ignored.
REQ-016 hp_quotient and Exceptions SHALL update only at the done edge and hold until the next done.
REQ-017 Sign SHALL be A_sign XOR B_sign.
REQ-018 Exponent SHALL be A_exp - B_exp + 15, computed 7-bit signed.
REQ-019 Mantissa SHALL be {1, frac}, or 0 when operand[14:0] == 0; subnormals are not supported (exp 0 with non-zero fraction is treated as a normal number with a hidden 1).
REQ-020 Mantissa division SHALL be restoring: remainder R = ma; for i = 11 down to 0: if R >= mb then q[i] = 1 and R = R - mb; then R = R << 1.
REQ-021 NORM SHALL produce: if q[11] = 1, frac = q[10:1]; else frac = q[9:0] and exponent decremented by 1.
REQ-022 Truncation SHALL be used, with no rounding.
REQ-023 Result priority SHALL be: (a) A_exp == 31, B_exp == 31 or hp_inB[14:0] == 0 -> {sign, 5'd31, 10'd0}, Exceptions 11; (b) hp_inA[14:0] == 0 -> {sign, 15'd0}, 00; (c) final exp >= 31 -> {sign, 5'd31, 10'd0}, 01; (d) final exp <= 0 -> {sign, 15'd0}, 10; (e) else {sign, exp[4:0], frac}, 00.

Reset
REQ-024 rst SHALL return the FSM to IDLE and zero hp_quotient, Exceptions, busy, done and all datapath registers.
REQ-025 rst mid-operation SHALL abort the operation with no done pulse.
REQ-026 rst SHALL have priority over start in the same cycle.

Structure
REQ-027 Package hp_fp_pkg SHALL hold: EXP_BIAS = 15, EXP_MAX = 31, MANT_W = 11, ITER = 12, the exception code constants, and the FSM state typedef.
REQ-028 There SHALL be one sub-module, hp_div_mant: the iterative restoring mantissa divider (load, step, 12-bit quotient out), driven by the top-level FSM.

Verification
REQ-029 A=16'h4000, B=16'h3C00, start -> hp_quotient 16'h4000, Exceptions 00, done exactly 14 cycles after the start edge.
REQ-030 A=16'h3C00, B=16'h4200 -> 16'h3555, 00 (normalise path taken, exponent decremented); A=16'hC600, B=16'h4000 -> 16'hC200, 00.
REQ-031 A=16'h3C00, B=16'h0000 -> 16'h7C00, 11; A=16'h0000, B=16'h4000 -> 16'h0000, 00.
REQ-032 A=16'h7BFF, B=16'h0400 -> 16'h7C00, 01; A=16'h0400, B=16'h7800 -> 16'h0000, 10.
REQ-033 Start 16'h4000/16'h3C00, pulse start again at cycle 5 with new operands -> second start ignored, single done, result 16'h4000.
REQ-034 Start, then rst at cycle 7 -> outputs all zero, no done; a new start after reset completes normally in 14 cycles.
